// File: rtl/ascon_bdo_packer.sv
// Unmasks Ascon bdo shares, buffers each output segment and emits header-framed words on a valid/ready port.
// Optional trailer word (XOR of frame data) when BDO_PACK_TRAILER_EN is defined.
module ascon_bdo_packer #(
   parameter int unsigned NUM_SHARES = 2,
   parameter int unsigned CCW        = 32,
   parameter int unsigned DEPTH      = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_SHARES*CCW-1:0]   bdo,
   input  logic                        bdo_valid,
   output logic                        bdo_ready,
   input  logic [3:0]                  bdo_type,
   input  logic                        bdo_eot,
   input  logic                        auth,
   input  logic                        auth_valid,
   output logic                        auth_ready,
   output logic [CCW-1:0]              out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
`ifdef BDO_PACK_TRAILER_EN
   localparam logic TRAILER = 1'b1;
`else
   localparam logic TRAILER = 1'b0;
`endif

   typedef enum logic [1:0] {COLLECT, HDR, DRAIN, AUTH} state_t;

   state_t          state_q, nxt_state;
   logic [CW-1:0]   count_q, nxt_count;
   logic [CW-1:0]   rd_q, nxt_rd;
   logic [3:0]      seg_type_q, nxt_type;
   logic            cont_q, nxt_cont;
   logic            auth_q, nxt_auth;
   logic [CCW-1:0]  acc_q, nxt_acc;
   logic            run_q;
   logic [CCW-1:0]  mem [DEPTH];

   logic [CCW-1:0]  word_c;
   logic            idle_c, type_ok_c, accept_c;
   logic [CW-1:0]   last_idx_c;
   logic [CCW-1:0]  nxt_out_data;
   logic            nxt_out_valid, nxt_out_last;

   // Recombine Boolean shares; only the unmasked word is ever stored
   always_comb begin
      word_c = '0;
      for (int unsigned i = 0; i < NUM_SHARES; i++) word_c = word_c ^ bdo[i*CCW +: CCW];
   end

   // Auth takes precedence over bdo only while the buffer is empty
   assign idle_c     = run_q && (state_q == COLLECT);
   assign type_ok_c  = (count_q == '0) ? !auth_valid : (bdo_type == seg_type_q);
   assign bdo_ready  = idle_c && (count_q < CW'(DEPTH)) && type_ok_c;
   assign auth_ready = idle_c && (count_q == '0) && auth_valid;
   assign accept_c   = bdo_valid && bdo_ready;
   assign last_idx_c = TRAILER ? count_q : count_q - CW'(1);

   always_comb begin
      nxt_state = state_q;
      nxt_count = count_q;
      nxt_rd    = rd_q;
      nxt_type  = seg_type_q;
      nxt_cont  = cont_q;
      nxt_auth  = auth_q;
      nxt_acc   = acc_q;
      case (state_q)
         COLLECT: begin
            if (accept_c) begin
               nxt_count = count_q + CW'(1);
               if (count_q == '0) begin
                  nxt_type = bdo_type;
                  nxt_acc  = word_c;
               end else begin
                  nxt_acc  = acc_q ^ word_c;
               end
               if (bdo_eot) begin
                  nxt_state = HDR;
                  nxt_cont  = 1'b0;
               end else if (count_q == CW'(DEPTH - 1)) begin
                  nxt_state = HDR;
                  nxt_cont  = 1'b1;
               end
            end else if (bdo_valid && (count_q != '0) && (bdo_type != seg_type_q)) begin
               nxt_state = HDR;
               nxt_cont  = 1'b0;
            end else if (auth_ready) begin
               nxt_auth  = auth;
               nxt_state = AUTH;
            end
         end
         HDR: begin
            if (out_ready) begin
               nxt_state = DRAIN;
               nxt_rd    = '0;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (rd_q == last_idx_c) begin
                  nxt_state = COLLECT;
                  nxt_count = '0;
                  nxt_rd    = '0;
               end else begin
                  nxt_rd    = rd_q + CW'(1);
               end
            end
         end
         AUTH: begin
            if (out_ready) nxt_state = COLLECT;
         end
         default: nxt_state = COLLECT;
      endcase
   end

   // Output word for the state being entered, so out_* come straight from flops
   always_comb begin
      nxt_out_valid = (nxt_state != COLLECT);
      nxt_out_last  = 1'b0;
      nxt_out_data  = '0;
      case (nxt_state)
         HDR:   nxt_out_data = {nxt_type, 2'b00, nxt_cont, TRAILER, 24'({nxt_count, 2'b00})};
         DRAIN: begin
            if (TRAILER && (nxt_rd == count_q)) nxt_out_data = acc_q;
            else                                nxt_out_data = mem[nxt_rd[AW-1:0]];
            nxt_out_last = (nxt_rd == last_idx_c);
         end
         AUTH: begin
            nxt_out_data = {4'hF, 3'b000, nxt_auth, 24'h0};
            nxt_out_last = 1'b1;
         end
         default: nxt_out_data = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= COLLECT;
         count_q    <= '0;
         rd_q       <= '0;
         seg_type_q <= '0;
         cont_q     <= 1'b0;
         auth_q     <= 1'b0;
         acc_q      <= '0;
         run_q      <= 1'b0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
      end else begin
         state_q    <= nxt_state;
         count_q    <= nxt_count;
         rd_q       <= nxt_rd;
         seg_type_q <= nxt_type;
         cont_q     <= nxt_cont;
         auth_q     <= nxt_auth;
         acc_q      <= nxt_acc;
         run_q      <= 1'b1;
         out_data   <= nxt_out_data;
         out_valid  <= nxt_out_valid;
         out_last   <= nxt_out_last;
      end
   end

   // Segment buffer; write pointer is the word count
   always_ff @(posedge clk) begin
      if (accept_c) mem[count_q[AW-1:0]] <= word_c;
   end

endmodule

// File: tb/tb_ascon_bdo_packer.sv
// Directed self-checking bench for ascon_bdo_packer; follows BDO_PACK_TRAILER_EN for expected framing.
module tb_ascon_bdo_packer;

`ifdef BDO_PACK_TRAILER_EN
   localparam logic TRL = 1'b1;
`else
   localparam logic TRL = 1'b0;
`endif
   localparam logic [3:0] D_PTCT = 4'h3;
   localparam logic [3:0] D_TAG  = 4'h8;
   localparam logic [3:0] D_HASH = 4'h9;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] bdo;
   logic        bdo_valid, bdo_ready, bdo_eot, auth, auth_valid, auth_ready;
   logic [3:0]  bdo_type;
   logic [31:0] out_data;
   logic        out_valid, out_ready, out_last;

   int checks = 0;
   int fails  = 0;

   logic [31:0] got_d[$], exp_d[$], sw[$];
   logic        got_l[$], exp_l[$];

   ascon_bdo_packer #(.NUM_SHARES(2), .CCW(32), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .bdo(bdo), .bdo_valid(bdo_valid), .bdo_ready(bdo_ready),
      .bdo_type(bdo_type), .bdo_eot(bdo_eot), .auth(auth), .auth_valid(auth_valid),
      .auth_ready(auth_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last)
   );

   always #5 clk = ~clk;

   // Record every output handshake, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         got_d.push_back(out_data);
         got_l.push_back(out_last);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Present one masked word and hold it until the packer takes it
   task automatic send(input logic [31:0] s0, input logic [31:0] s1, input logic [3:0] t, input logic e);
      int   n;
      logic a;
      bdo = {s1, s0}; bdo_type = t; bdo_eot = e; bdo_valid = 1'b1;
      a = 1'b0; n = 0;
      while (!a && n < 200) begin
         @(negedge clk); a = bdo_ready;
         @(posedge clk); #1; n++;
      end
      bdo_valid = 1'b0; bdo_eot = 1'b0;
      checks++;
      if (!a) begin
         fails++;
         $display("FAIL send_timeout: word %h never accepted", s0 ^ s1);
      end
   endtask

   // Expected frame for the words currently in sw
   task automatic exp_seg(input logic [3:0] t, input logic cont);
      logic [31:0] x;
      x = '0;
      exp_d.push_back({t, 2'b00, cont, TRL, 24'(sw.size() * 4)});
      exp_l.push_back(1'b0);
      foreach (sw[i]) begin
         exp_d.push_back(sw[i]);
         exp_l.push_back(!TRL && (i == sw.size() - 1));
         x = x ^ sw[i];
      end
      if (TRL) begin
         exp_d.push_back(x);
         exp_l.push_back(1'b1);
      end
      sw.delete();
   endtask

   task automatic clear_q();
      got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; bdo = '0; bdo_valid = 0; bdo_type = '0; bdo_eot = 0;
      auth = 0; auth_valid = 0; out_ready = 1'b1;
      #3;
      checks++;
      if ({out_valid, out_last, bdo_ready, auth_ready} !== 4'b0000 || out_data !== 32'h0) begin
         fails++;
         $display("FAIL reset_outputs: v=%b l=%b br=%b ar=%b d=%h, need all 0",
                  out_valid, out_last, bdo_ready, auth_ready, out_data);
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bdo_ready !== 1'b0) begin
         fails++;
         $display("FAIL ready_before_edge: bdo_ready=%b need 0", bdo_ready);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (bdo_ready !== 1'b1) begin
         fails++;
         $display("FAIL ready_after_edge: bdo_ready=%b need 1", bdo_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_encrypt();
      int n;
      clear_q();
      send(32'h11111111, 32'h01234567, D_PTCT, 1'b0);
      send(32'h00000000, 32'hDEADBEEF, D_PTCT, 1'b0);
      send(32'hFFFFFFFF, 32'h0F0F0F0F, D_PTCT, 1'b1);
      sw = '{32'h10325476, 32'hDEADBEEF, 32'hF0F0F0F0};
      exp_seg(D_PTCT, 1'b0);
      n = 0;
      while (got_d.size() < exp_d.size() && n < 300) begin @(posedge clk); #1; n++; end
      checks++;
      if (got_d.size() != exp_d.size()) begin
         fails++;
         $display("FAIL encrypt_count: got %0d words need %0d", got_d.size(), exp_d.size());
      end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
            fails++;
            $display("FAIL encrypt_word%0d: got %h/%b need %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
         end
      end
   endtask

   task automatic test_overflow();
      int n;
      clear_q();
      for (int i = 0; i < 10; i++) begin
         send(32'h10000000 + 32'(i), 32'h0F0F0F0F, D_PTCT, i == 9);
         sw.push_back((32'h10000000 + 32'(i)) ^ 32'h0F0F0F0F);
         if (i == 7) exp_seg(D_PTCT, 1'b1);
      end
      exp_seg(D_PTCT, 1'b0);
      n = 0;
      while (got_d.size() < exp_d.size() && n < 300) begin @(posedge clk); #1; n++; end
      checks++;
      if (got_d.size() != exp_d.size()) begin
         fails++;
         $display("FAIL overflow_count: got %0d words need %0d", got_d.size(), exp_d.size());
      end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
            fails++;
            $display("FAIL overflow_word%0d: got %h/%b need %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
         end
      end
   endtask

   task automatic test_type_change();
      int n;
      clear_q();
      send(32'hAAAA0001, 32'h00000000, D_PTCT, 1'b0);
      send(32'hAAAA0002, 32'h00000000, D_PTCT, 1'b0);
      bdo = {32'h0, 32'h7A700001}; bdo_type = D_TAG; bdo_eot = 1'b1; bdo_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (bdo_ready !== 1'b0) begin
         fails++;
         $display("FAIL type_change_ready: bdo_ready=%b need 0", bdo_ready);
      end
      @(posedge clk); #1;
      send(32'h7A700001, 32'h00000000, D_TAG, 1'b1);
      sw = '{32'hAAAA0001, 32'hAAAA0002};
      exp_seg(D_PTCT, 1'b0);
      sw = '{32'h7A700001};
      exp_seg(D_TAG, 1'b0);
      n = 0;
      while (got_d.size() < exp_d.size() && n < 300) begin @(posedge clk); #1; n++; end
      checks++;
      if (got_d.size() != exp_d.size()) begin
         fails++;
         $display("FAIL type_change_count: got %0d words need %0d", got_d.size(), exp_d.size());
      end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
            fails++;
            $display("FAIL type_change_word%0d: got %h/%b need %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
         end
      end
   endtask

   task automatic test_auth();
      int n;
      clear_q();
      auth = 1'b1; auth_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (auth_ready !== 1'b1) begin
         fails++;
         $display("FAIL auth_ready_pulse: auth_ready=%b need 1", auth_ready);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (auth_ready !== 1'b0) begin
         fails++;
         $display("FAIL auth_ready_width: auth_ready=%b need 0", auth_ready);
      end
      @(posedge clk); #1;
      auth_valid = 1'b0;
      exp_d.push_back(32'hF1000000); exp_l.push_back(1'b1);
      // auth and bdo together while empty: auth must win
      auth = 1'b0; auth_valid = 1'b1;
      bdo = {32'h12345678, 32'h0}; bdo_type = D_HASH; bdo_eot = 1'b1; bdo_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (auth_ready !== 1'b1 || bdo_ready !== 1'b0) begin
         fails++;
         $display("FAIL auth_priority: auth_ready=%b bdo_ready=%b need 1/0", auth_ready, bdo_ready);
      end
      @(posedge clk); #1;
      auth_valid = 1'b0;
      exp_d.push_back(32'hF0000000); exp_l.push_back(1'b1);
      send(32'h00000000, 32'h12345678, D_HASH, 1'b1);
      sw = '{32'h12345678};
      exp_seg(D_HASH, 1'b0);
      n = 0;
      while (got_d.size() < exp_d.size() && n < 300) begin @(posedge clk); #1; n++; end
      checks++;
      if (got_d.size() != exp_d.size()) begin
         fails++;
         $display("FAIL auth_count: got %0d words need %0d", got_d.size(), exp_d.size());
      end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
            fails++;
            $display("FAIL auth_word%0d: got %h/%b need %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      clear_q();
      send(32'h0000BEEF, 32'hCAFE0000, D_PTCT, 1'b0);
      send(32'h55555555, 32'hAAAAAAAA, D_PTCT, 1'b0);
      send(32'h01010101, 32'h10101010, D_PTCT, 1'b1);
      @(posedge clk); #1;
      // now in DRAIN showing the first data word
      out_ready = 1'b0;
      bdo = {32'h0, 32'h99999999}; bdo_type = D_PTCT; bdo_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== 32'hCAFEBEEF || out_last !== 1'b0 || bdo_ready !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_hold%0d: v=%b d=%h l=%b br=%b need 1/cafebeef/0/0",
                     c, out_valid, out_data, out_last, bdo_ready);
         end
         @(posedge clk); #1;
      end
      bdo_valid = 1'b0;
      out_ready = 1'b1;
      sw = '{32'hCAFEBEEF, 32'hFFFFFFFF, 32'h11111111};
      exp_seg(D_PTCT, 1'b0);
      n = 0;
      while (got_d.size() < exp_d.size() && n < 300) begin @(posedge clk); #1; n++; end
      repeat (4) begin @(posedge clk); #1; end
      checks++;
      if (got_d.size() != exp_d.size()) begin
         fails++;
         $display("FAIL backpressure_count: got %0d words need %0d", got_d.size(), exp_d.size());
      end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
            fails++;
            $display("FAIL backpressure_word%0d: got %h/%b need %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      int n;
      clear_q();
      send(32'h11110000, 32'h00002222, D_PTCT, 1'b0);
      send(32'h33330000, 32'h00004444, D_PTCT, 1'b1);
      @(posedge clk); #1;
      #1 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0 || bdo_ready !== 1'b0) begin
         fails++;
         $display("FAIL async_reset: v=%b l=%b d=%h br=%b need 0/0/0/0", out_valid, out_last, out_data, bdo_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      clear_q();
      send(32'h0BADF00D, 32'h00000000, D_HASH, 1'b1);
      sw = '{32'h0BADF00D};
      exp_seg(D_HASH, 1'b0);
      n = 0;
      while (got_d.size() < exp_d.size() && n < 300) begin @(posedge clk); #1; n++; end
      checks++;
      if (got_d.size() != exp_d.size()) begin
         fails++;
         $display("FAIL post_reset_count: got %0d words need %0d", got_d.size(), exp_d.size());
      end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
            fails++;
            $display("FAIL post_reset_word%0d: got %h/%b need %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_encrypt();
      test_overflow();
      test_type_change();
      test_auth();
      test_backpressure();
      test_reset_mid_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/ascon_bdo_packer.md
Name: ascon_bdo_packer

Overview:
- Host-side consumer of the masked Ascon core output interface (bdo/auth); the counterpart to the instruction-stream driver that feeds key/bdi.
- Recombines bdo shares by XOR, buffers each output segment, and emits a framed word stream on a valid/ready port.
- Each frame is a header word followed by data words, matching the INS/DAT test-vector framing: type in [31:28], flags in [27:24], byte length in [23:0].
- Tag-verification results are framed as header-only records.

Parameters:
- NUM_SHARES, 2, number of Boolean shares on bdo.
- CCW, 32, unmasked word width; must be 32.
- DEPTH, 8, segment buffer depth in words; power of two, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- bdo  in  NUM_SHARES*CCW  masked output word; share i is at [i*CCW +: CCW]
- bdo_valid  in  1  core output word valid
- bdo_ready  out  1  packer accepts bdo word
- bdo_type  in  4  segment type (D_PTCT, D_TAG, D_HASH)
- bdo_eot  in  1  last word of segment
- auth  in  1  tag verification result
- auth_valid  in  1  verification result valid
- auth_ready  out  1  packer accepts auth
- out_data  out  CCW  framed output word
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts out_data
- out_last  out  1  last word of current frame

Behaviour:
- Reset (async, any state): state=COLLECT, count=0, all buffer pointers 0. Outputs: bdo_ready=0, auth_ready=0, out_valid=0, out_last=0, out_data=0. bdo_ready and auth_ready rise only after the first clock edge with rst low.
- Unmask: word = XOR over all shares of bdo. Only the unmasked word is stored.
- States: COLLECT, HDR, DRAIN, AUTH.
- COLLECT:
  - bdo_ready=1 when count<DEPTH and (count==0 or bdo_type==seg_type).
  - Accept on bdo_valid&bdo_ready: write word to buffer, count++. On the first word, latch seg_type=bdo_type.
  - Go to HDR the cycle after the accept when (a) bdo_eot is accepted (flag cont=0), or (b) count reaches DEPTH without eot (flag cont=1).
  - Go to HDR when bdo_valid, count>0, and bdo_type!=seg_type: that word is not accepted, cont=0.
  - Otherwise, if count==0 and auth_valid: auth_ready=1 for exactly that cycle, latch auth, go to AUTH.
  - bdo has priority over auth only when count>0. When count==0 and both valid in the same cycle, auth wins.
- HDR:
  - out_valid=1, out_data={seg_type, 2'b00, cont, 1'b0, count*4 as 24 bits}.
  - out_last=0. The header is never the last word because count≥1.
  - On out_ready go to DRAIN.
- DRAIN:
  - out_valid=1, out_data=buffer words in arrival order.
  - out_last=1 on the final word.
  - On the final handshake: count=0, go to COLLECT.
  - A segment with cont=1 resumes in COLLECT with the same seg_type.
- AUTH:
  - out_valid=1, out_data={4'hF, 3'b000, auth, 24'h0}, out_last=1.
  - On out_ready go to COLLECT.
- Backpressure: out_data/out_valid/out_last are held stable while out_valid&!out_ready. bdo_ready=0 and auth_ready=0 in HDR, DRAIN and AUTH.
- Latency: eot accepted at edge N → header valid at edge N+1. Throughput is one word per cycle in each direction; no overlap of collect and drain.

Optional Feature:
- Macro BDO_PACK_TRAILER_EN.
- Defined:
  - After the last data word, DRAIN emits one trailer word: the XOR of all data words in the frame.
  - out_last moves from the final data word to the trailer.
  - The header length field is unchanged (data bytes only).
  - The header flag bit [24] is set to 1 to announce the trailer.
- Not defined: no trailer; bit [24]=0; behaviour exactly as in Behaviour.

Test Plan:
- Encrypt, 3 data words:
  - Stimulus: PTCT words with share0=0x11111111/share1=0x01234567, 0x0/0xDEADBEEF, 0xFFFFFFFF/0x0F0F0F0F (eot).
  - Required: out 0x3000000C (D_PTCT=3 assumed), then 0x10325476, 0xDEADBEEF, 0xF0F0F0F0 with last.
- Overflow split, DEPTH=8, 10-word PTCT segment:
  - Required: header 0x32000020 then 8 words.
  - Then header 0x30000008 then 2 words, last on the final word.
- Type change without eot:
  - Stimulus: 2 PTCT words, then a TAG word.
  - Required: bdo_ready=0 on the TAG cycle; PTCT frame length 8; then the TAG frame.
- auth_valid with auth=1 while idle:
  - Required: auth_ready pulses 1 cycle; out 0xF1000000 with last.
  - With auth=0: out 0xF0000000.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles during DRAIN.
  - Required: out_data stable; bdo_ready=0 throughout; no word lost or duplicated.
- Async reset mid-DRAIN:
  - Stimulus: assert rst mid-DRAIN.
  - Required: out_valid=0 immediately (no clock edge needed).
  - A new 1-word hash segment is then framed correctly as header (length 4) plus 1 word.
  - Repeat with BDO_PACK_TRAILER_EN: trailer equals the XOR of the data words, header bit [24]=1.
